// File: rtl/lsu_ctrl_if.sv
// Request/response and data_mem bus bundle for lsu_ctrl.
// The master side is the execute stage plus data_mem; the slave side is lsu_ctrl itself.
interface lsu_ctrl_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [DATA_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_fault;
  logic [ADDRESS_WIDTH-1:0] mem_A;
  logic [DATA_WIDTH-1:0]    mem_WD;
  logic                     mem_WE0;
  logic                     mem_WE1;
  logic                     mem_WE2;
  logic                     mem_WE3;
  logic [DATA_WIDTH-1:0]    mem_RD;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_A, mem_WD, mem_WE0, mem_WE1, mem_WE2, mem_WE3
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_A, mem_WD, mem_WE0, mem_WE1, mem_WE2, mem_WE3
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of data_mem: legality check, byte-lane stores, load extension.
// Define LSU_MISALIGN_FAULT_EN to reject misaligned halfword/word accesses.
module lsu_ctrl #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic       CLK,
  input  logic       RST_N,
  lsu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [DATA_WIDTH:0] MEM_BYTES =
    {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, 1'b1, {ADDRESS_WIDTH{1'b0}}};

  state_t                   state;
  logic                     ready;
  logic                     rsp_valid;
  logic                     rsp_fault;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic [ADDRESS_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0]    wd_p0;
  logic [3:0]               lanes_p0;
  logic                     we_p0;
  logic [2:0]               funct3_p0;

  logic                     illegal;
  logic                     out_of_range;
  logic                     misalign;
  logic                     fault;
  logic [2:0]               size;
  logic [DATA_WIDTH:0]      end_addr;

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0] f3,
                                                        input logic [DATA_WIDTH-1:0] rd);
    case (f3)
      3'b000:  return {{24{rd[7]}}, rd[7:0]};
      3'b001:  return {{16{rd[15]}}, rd[15:0]};
      3'b100:  return {24'd0, rd[7:0]};
      3'b101:  return {16'd0, rd[15:0]};
      default: return rd;
    endcase
  endfunction

  // data_mem places WD[31:24] at A, so the LSB-aligned store data is byte-reversed.
  function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3);
    case (f3)
      3'b000:  return 4'b0001;
      3'b001:  return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    illegal = 1'b0;
    size    = 3'd1;
    case (bus.req_funct3)
      3'b000:  size = 3'd1;
      3'b001:  size = 3'd2;
      3'b010:  size = 3'd4;
      3'b100:  begin size = 3'd1; illegal = bus.req_we; end
      3'b101:  begin size = 3'd2; illegal = bus.req_we; end
      default: illegal = 1'b1;
    endcase
    // Widened sum so any upper address bit or carry lands above the memory size.
    end_addr     = {1'b0, bus.req_addr} + {{(DATA_WIDTH-2){1'b0}}, size};
    out_of_range = end_addr > MEM_BYTES;
`ifdef LSU_MISALIGN_FAULT_EN
    misalign = ((size == 3'd2) && bus.req_addr[0]) ||
               ((size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = illegal || out_of_range || misalign;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ready     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_data  <= '0;
      addr_p0   <= '0;
      wd_p0     <= '0;
      lanes_p0  <= 4'b0000;
      we_p0     <= 1'b0;
      funct3_p0 <= 3'b000;
    end else begin
      case (state)
        // Accept boundary: capture request, faulting requests skip the memory.
        IDLE: begin
          if (bus.req_valid) begin
            we_p0     <= bus.req_we;
            funct3_p0 <= bus.req_funct3;
            rsp_fault <= fault;
            rsp_data  <= '0;
            ready     <= 1'b0;
            if (fault) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              addr_p0  <= bus.req_addr[ADDRESS_WIDTH-1:0];
              wd_p0    <= byte_swap(bus.req_wdata);
              lanes_p0 <= bus.req_we ? store_lanes(bus.req_funct3) : 4'b0000;
              state    <= ACCESS;
            end
          end
        end
        // Access boundary: store commits on this edge, load data is captured.
        ACCESS: begin
          lanes_p0  <= 4'b0000;
          rsp_valid <= 1'b1;
          if (!we_p0) rsp_data <= load_extend(funct3_p0, bus.mem_RD);
          state <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          lanes_p0  <= 4'b0000;
          ready     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = rsp_valid;
  assign bus.resp_fault = rsp_fault;
  assign bus.resp_rdata = rsp_data;
  assign bus.mem_A      = addr_p0;
  assign bus.mem_WD     = wd_p0;
  assign bus.mem_WE0    = lanes_p0[0];
  assign bus.mem_WE1    = lanes_p0[1];
  assign bus.mem_WE2    = lanes_p0[2];
  assign bus.mem_WE3    = lanes_p0[3];

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a byte-array data_mem model (A holds WD[31:24]).
module tb_lsu_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [3:0]  lanes;
    logic [31:0] wd;
    logic [8:0]  addr;
    int          cyc;
  } wr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;

  rsp_t rq[$];
  wr_t  wq[$];
  rsp_t r;
  wr_t  w;

  logic [7:0] mem [0:511];
  logic [8:0] a1, a2, a3;
  logic [3:0] lanes;

  lsu_ctrl_if #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) bus ();

  lsu_ctrl #(.ADDRESS_WIDTH(9), .DATA_WIDTH(32)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign a1    = bus.mem_A + 9'd1;
  assign a2    = bus.mem_A + 9'd2;
  assign a3    = bus.mem_A + 9'd3;
  assign lanes = {bus.mem_WE3, bus.mem_WE2, bus.mem_WE1, bus.mem_WE0};
  assign bus.mem_RD = {mem[a3], mem[a2], mem[a1], mem[bus.mem_A]};

  always @(posedge clk) begin
    if (bus.mem_WE0) mem[bus.mem_A] <= bus.mem_WD[31:24];
    if (bus.mem_WE1) mem[a1]        <= bus.mem_WD[23:16];
    if (bus.mem_WE2) mem[a2]        <= bus.mem_WD[15:8];
    if (bus.mem_WE3) mem[a3]        <= bus.mem_WD[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: every WE cycle and every response must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lanes != 4'b0000) begin
        if (wq.size() == 0) chk("we_unexpected", {28'd0, lanes}, 32'd0);
        else begin
          w = wq.pop_front();
          chk("we_lanes", {28'd0, lanes}, {28'd0, w.lanes});
          chk("mem_wd", bus.mem_WD, w.wd);
          chk("mem_a", {23'd0, bus.mem_A}, {23'd0, w.addr});
          chk("we_cycle", cyc, w.cyc);
        end
      end
      if (bus.resp_valid) begin
        if (rq.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          r = rq.pop_front();
          chk("resp_rdata", bus.resp_rdata, r.rdata);
          chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, r.fault});
          chk("resp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_flt, input logic [3:0] exp_lanes,
                       input logic [31:0] exp_wd);
    int n;
    int acc;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      acc            = cyc + 1;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      rq.push_back('{rdata: exp_rd, fault: exp_flt, cyc: exp_flt ? acc : acc + 1});
      if (exp_lanes != 4'b0000)
        wq.push_back('{lanes: exp_lanes, wd: exp_wd, addr: addr[8:0], cyc: acc});
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_mem_a", {23'd0, bus.mem_A}, 32'd0);
    chk("rst_mem_wd", bus.mem_WD, 32'd0);
    chk("rst_we", {28'd0, lanes}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Word store then load back.
    issue(1'b1, 3'b010, 32'h010, 32'h11223344, 32'h0, 1'b0, 4'b1111, 32'h44332211);
    issue(1'b0, 3'b010, 32'h010, 32'h0, 32'h11223344, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 3'b001, 32'h010, 32'h0, 32'h00003344, 1'b0, 4'b0000, 32'h0);
    // Byte store, signed and unsigned byte loads.
    issue(1'b1, 3'b000, 32'h013, 32'h000000AB, 32'h0, 1'b0, 4'b0001, 32'hAB000000);
    issue(1'b0, 3'b000, 32'h013, 32'h0, 32'hFFFFFFAB, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 3'b100, 32'h013, 32'h0, 32'h000000AB, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h010, 32'h0, 32'hAB223344, 1'b0, 4'b0000, 32'h0);
    // Top-of-memory boundary: last word legal, past-the-end faults.
    issue(1'b1, 3'b010, 32'h1FC, 32'hCAFEF00D, 32'h0, 1'b0, 4'b1111, 32'h0DF0FECA);
    issue(1'b0, 3'b010, 32'h1FC, 32'h0, 32'hCAFEF00D, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 3'b101, 32'h1FE, 32'h0, 32'h0000CAFE, 1'b0, 4'b0000, 32'h0);
    issue(1'b0, 3'b000, 32'h1FF, 32'h0, 32'hFFFFFFCA, 1'b0, 4'b0000, 32'h0);
    issue(1'b1, 3'b001, 32'h1FF, 32'h5555, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h80000010, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h1FD, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    // Illegal funct3 encodings.
    issue(1'b0, 3'b011, 32'h010, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b1, 3'b100, 32'h010, 32'h99, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b111, 32'h010, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    issue(1'b0, 3'b010, 32'h010, 32'h0, 32'hAB223344, 1'b0, 4'b0000, 32'h0);
    // Misaligned halfword at 0x021 holding 0x80FF.
    issue(1'b1, 3'b000, 32'h021, 32'h000000FF, 32'h0, 1'b0, 4'b0001, 32'hFF000000);
    issue(1'b1, 3'b000, 32'h022, 32'h00000080, 32'h0, 1'b0, 4'b0001, 32'h80000000);
`ifdef LSU_MISALIGN_FAULT_EN
    issue(1'b0, 3'b001, 32'h021, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
`else
    issue(1'b0, 3'b001, 32'h021, 32'h0, 32'hFFFF80FF, 1'b0, 4'b0000, 32'h0);
`endif

    // Reset during a store's ACCESS cycle must abort it.
    issue(1'b1, 3'b010, 32'h040, 32'hDEADBEEF, 32'h0, 1'b0, 4'b1111, 32'hEFBEADDE);
    repeat (4) @(negedge clk);
    chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h040;
    bus.req_wdata  = 32'h01020304;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    chk("abort_we_before", {28'd0, lanes}, 32'hF);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_we_dropped", {28'd0, lanes}, 32'd0);
    chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b1;
    bus.req_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_we", {28'd0, lanes}, 32'd0);
    chk("rst_hold_resp", {31'd0, bus.resp_valid}, 32'd0);
    bus.req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
    issue(1'b0, 3'b010, 32'h040, 32'h0, 32'hDEADBEEF, 1'b0, 4'b0000, 32'h0);

    repeat (10) @(negedge clk);
    chk("sb_resp_empty", rq.size(), 32'd0);
    chk("sb_we_empty", wq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
